// File: rtl/c3lib_ckg_req_ack_ctl.sv
// ---------------------------------------------------------------------------
// c3lib_ckg_req_ack_ctl
//
// Clock-enable sequencer for a downstream c3lib clock gater. It turns a
// level clock request into a registered, glitch-free enable. It acknowledges
// only after a wake-up settle period. After the request drops, it keeps the
// clock running for an idle hysteresis period.
// This block runs on the free-running source clock, upstream of the gater.
//
// Ports:
//   clk      in   free-running (ungated) source clock
//   rst      in   asynchronous active-high reset
//   req      in   level clock request from consumers (sync to clk)
//   force_on in   debug override, treated as req=1 while high
//   clk_en   out  registered enable to the clock gater
//   ack      out  clock running and settled; consumers may proceed
//   state    out  FSM state: OFF=0, WAKE=1, ON=2, HOLD=3
//
// Parameters:
//   WAKE_CYC  cycles from clk_en rise to ack rise      (1..2^CNT_W-1)
//   IDLE_CYC  cycles clk_en is held after want drops   (1..2^CNT_W-1)
//   CNT_W     width of the shared settle/idle counter
// ---------------------------------------------------------------------------
module c3lib_ckg_req_ack_ctl #(
  parameter int WAKE_CYC = 2,
  parameter int IDLE_CYC = 8,
  parameter int CNT_W    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic       force_on,
  output logic       clk_en,
  output logic       ack,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_WAKE = 2'd1,
    ST_ON   = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  // Terminal counts. The counter restarts at zero on every state entry and
  // only counts up to these values, so it can never wrap.
  localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'(WAKE_CYC - 1);
  localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYC - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             clk_en_q, clk_en_d;
  logic             ack_q, ack_d;
  logic             want;

  assign want = req | force_on;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    clk_en_d = clk_en_q;
    ack_d    = ack_q;
    case (state_q)
      ST_OFF: begin
        if (want) begin
          state_d  = ST_WAKE;
          clk_en_d = 1'b1;
          cnt_d    = '0;
        end
      end
      ST_WAKE: begin
        // The settle period always completes, even if want drops, so a
        // consumer never sees ack before the gated clock is stable.
        if (cnt_q == WAKE_LAST) begin
          state_d = ST_ON;
          ack_d   = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_ON: begin
        if (!want) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
        end
      end
      ST_HOLD: begin
        // A re-request takes priority over expiry. This keeps clk_en high
        // with no low glitch, even on the edge where the hold would expire.
        if (want) begin
          state_d = ST_ON;
          cnt_d   = '0;
        end else if (cnt_q == IDLE_LAST) begin
          state_d  = ST_OFF;
          clk_en_d = 1'b0;
          ack_d    = 1'b0;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d  = ST_OFF;
        clk_en_d = 1'b0;
        ack_d    = 1'b0;
        cnt_d    = '0;
      end
    endcase
  end

  // Asynchronous reset drops the enable immediately at any phase. The
  // gater's latch absorbs the mid-cycle enable fall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_OFF;
      cnt_q    <= '0;
      clk_en_q <= 1'b0;
      ack_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      clk_en_q <= clk_en_d;
      ack_q    <= ack_d;
    end
  end

  assign clk_en = clk_en_q;
  assign ack    = ack_q;
  assign state  = state_q;

endmodule

// File: tb/tb_c3lib_ckg_req_ack_ctl.sv
module tb_c3lib_ckg_req_ack_ctl;

  localparam int WAKE_CYC = 2;
  localparam int IDLE_CYC = 8;
  localparam int CNT_W    = 4;

  localparam logic [1:0] S_OFF  = 2'd0;
  localparam logic [1:0] S_WAKE = 2'd1;
  localparam logic [1:0] S_ON   = 2'd2;
  localparam logic [1:0] S_HOLD = 2'd3;

  logic       clk;
  logic       rst;
  logic       req;
  logic       force_on;
  logic       clk_en;
  logic       ack;
  logic [1:0] state;

  // Scoreboard entries hold {state, clk_en, ack}.
  logic [3:0] sb_q[$];
  logic [3:0] exp_v;
  int         checks;
  int         passed;

  c3lib_ckg_req_ack_ctl #(
    .WAKE_CYC(WAKE_CYC),
    .IDLE_CYC(IDLE_CYC),
    .CNT_W   (CNT_W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .force_on(force_on),
    .clk_en  (clk_en),
    .ack     (ack),
    .state   (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", passed, checks);
    $fatal(1);
  end

  // Push n expected cycles in state st. The enable and ack values come from
  // the output relations: enable is high outside OFF, and ack is high in ON
  // and HOLD.
  function automatic void expect_n(input logic [1:0] st, input int n);
    for (int i = 0; i < n; i++)
      sb_q.push_back({st, (st != S_OFF), (st == S_ON || st == S_HOLD)});
  endfunction

  task automatic tick(input logic r, input logic f);
    req      = r;
    force_on = f;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 1'b0; force_on = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({state, clk_en, ack} !== 4'b0000)
      $display("FAIL reset: got state=%0d clk_en=%b ack=%b, expected 0/0/0", state, clk_en, ack);
    else passed++;
    #3 rst = 1'b0;
    tick(1'b0, 1'b0);
    checks++;
    if ({state, clk_en, ack} !== 4'b0000)
      $display("FAIL reset_idle: got state=%0d clk_en=%b ack=%b, expected 0/0/0", state, clk_en, ack);
    else passed++;
  endtask

  // Starting in OFF, hold req until ON.
  task automatic test_wake(input logic use_force);
    expect_n(S_WAKE, WAKE_CYC);
    expect_n(S_ON, 2);
    for (int i = 0; i < WAKE_CYC + 2; i++) begin
      tick(!use_force, use_force);
      exp_v = sb_q.pop_front();
      checks++;
      if ({state, clk_en, ack} !== exp_v)
        $display("FAIL wake(force=%b) cyc%0d: got %0d/%b/%b expected %0d/%b/%b",
                 use_force, i, state, clk_en, ack, exp_v[3:2], exp_v[1], exp_v[0]);
      else passed++;
    end
  endtask

  // Starting in ON, drop the request and run the hold period down to OFF.
  task automatic test_idle();
    expect_n(S_HOLD, IDLE_CYC);
    expect_n(S_OFF, 1);
    for (int i = 0; i < IDLE_CYC + 1; i++) begin
      tick(1'b0, 1'b0);
      exp_v = sb_q.pop_front();
      checks++;
      if ({state, clk_en, ack} !== exp_v)
        $display("FAIL idle cyc%0d: got %0d/%b/%b expected %0d/%b/%b",
                 i, state, clk_en, ack, exp_v[3:2], exp_v[1], exp_v[0]);
      else passed++;
    end
  endtask

  // Starting in ON, re-raise req while the HOLD counter equals cnt_at.
  task automatic test_rerequest(input int cnt_at);
    expect_n(S_HOLD, cnt_at + 1);
    expect_n(S_ON, 2);
    for (int i = 0; i < cnt_at + 3; i++) begin
      tick((i > cnt_at), 1'b0);
      exp_v = sb_q.pop_front();
      checks++;
      if ({state, clk_en, ack} !== exp_v)
        $display("FAIL rerequest(cnt=%0d) cyc%0d: got %0d/%b/%b expected %0d/%b/%b",
                 cnt_at, i, state, clk_en, ack, exp_v[3:2], exp_v[1], exp_v[0]);
      else passed++;
    end
  endtask

  // Starting in OFF, a one-cycle pulse produces a complete on/off cycle.
  task automatic test_pulse();
    int en_cycles;
    en_cycles = 0;
    expect_n(S_WAKE, WAKE_CYC);
    expect_n(S_ON, 1);
    expect_n(S_HOLD, IDLE_CYC);
    expect_n(S_OFF, 2);
    for (int i = 0; i < WAKE_CYC + IDLE_CYC + 3; i++) begin
      tick((i == 0), 1'b0);
      if (clk_en) en_cycles++;
      exp_v = sb_q.pop_front();
      checks++;
      if ({state, clk_en, ack} !== exp_v)
        $display("FAIL pulse cyc%0d: got %0d/%b/%b expected %0d/%b/%b",
                 i, state, clk_en, ack, exp_v[3:2], exp_v[1], exp_v[0]);
      else passed++;
    end
    checks++;
    if (en_cycles !== 11)
      $display("FAIL pulse_en_len: got %0d clk_en cycles, expected 11", en_cycles);
    else passed++;
  endtask

  // Starting in ON via force_on, hand over to req, then release.
  task automatic test_force_handover();
    expect_n(S_ON, 2);
    for (int i = 0; i < 2; i++) begin
      tick(1'b1, 1'b0);
      exp_v = sb_q.pop_front();
      checks++;
      if ({state, clk_en, ack} !== exp_v)
        $display("FAIL force_handover cyc%0d: got %0d/%b/%b expected %0d/%b/%b",
                 i, state, clk_en, ack, exp_v[3:2], exp_v[1], exp_v[0]);
      else passed++;
    end
  endtask

  // Async reset is asserted mid-cycle after `pre` ticks of req_pre.
  // The bench then checks for an immediate drop and a fresh wake.
  task automatic test_async_reset(input logic req_pre, input int pre, input string tag);
    for (int i = 0; i < pre; i++) tick(req_pre, 1'b0);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({state, clk_en, ack} !== 4'b0000)
      $display("FAIL async_rst_%s: got state=%0d clk_en=%b ack=%b, expected 0/0/0",
               tag, state, clk_en, ack);
    else passed++;
    #1 rst = 1'b0;
    expect_n(S_WAKE, WAKE_CYC);
    expect_n(S_ON, 1);
    for (int i = 0; i < WAKE_CYC + 1; i++) begin
      tick(1'b1, 1'b0);
      exp_v = sb_q.pop_front();
      checks++;
      if ({state, clk_en, ack} !== exp_v)
        $display("FAIL rewake_%s cyc%0d: got %0d/%b/%b expected %0d/%b/%b",
                 tag, i, state, clk_en, ack, exp_v[3:2], exp_v[1], exp_v[0]);
      else passed++;
    end
  endtask

  initial begin
    checks = 0;
    passed = 0;
    test_reset();
    test_wake(1'b0);
    test_idle();
    test_wake(1'b0);
    test_rerequest(3);
    test_rerequest(IDLE_CYC - 1);
    test_idle();
    test_pulse();
    test_wake(1'b1);
    test_force_handover();
    test_idle();
    // Mid-WAKE: one req tick gives WAKE with cnt=0.
    test_async_reset(1'b1, 1, "wake");
    // Mid-HOLD: from ON, three low ticks leave HOLD with cnt=2.
    test_async_reset(1'b0, 3, "hold");
    test_idle();
    checks++;
    if (sb_q.size() != 0)
      $display("FAIL scoreboard_drain: got %0d leftover entries, expected 0", sb_q.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/c3lib_ckg_req_ack_ctl.md
# c3lib_ckg_req_ack_ctl

Clock-enable sequencer that drives the `clk_en` input of a downstream c3lib clock gater, for example the negedge gater. It turns a level-sensitive clock request from consuming logic into a registered, glitch-free enable. It returns an acknowledge only after a programmable wake-up settle period, and it holds the clock on for a programmable idle hysteresis after the request drops. It runs on the free-running (ungated) source clock, upstream of the gater; scan/test override (`tst_en`) remains at the gater and is not handled here.

## Interface
Parameters:
- `WAKE_CYC`, default 2 — cycles from `clk_en` rise to `ack` rise; legal range 1..2^CNT_W-1.
- `IDLE_CYC`, default 8 — cycles `clk_en` is held after the request drops; legal range 1..2^CNT_W-1.
- `CNT_W`, default 4 — width of the shared settle/idle counter.

Ports:
- `clk` input 1 — free-running source clock.
- `rst` input 1 — reset, one clock; reset is asynchronous and active-high.
- `req` input 1 — clock request from consumers, synchronous to `clk`, level.
- `force_on` input 1 — debug override; while high it is treated as `req`=1.
- `clk_en` output 1 — registered enable to the clock gater.
- `ack` output 1 — clock is running and settled; consumers may proceed.
- `state` output 2 — current FSM state: OFF=0, WAKE=1, ON=2, HOLD=3.

## Operation
- Define `want` = `req` | `force_on`, sampled on rising `clk`.
- Reset values: state=OFF, counter=0, `clk_en`=0, `ack`=0.
- OFF:
  - `want`=1 → go to WAKE; `clk_en`←1; cnt←0.
  - Otherwise stay in OFF.
- WAKE (`clk_en`=1, `ack`=0):
  - cnt==WAKE_CYC-1 → go to ON; `ack`←1.
  - Otherwise cnt←cnt+1.
  - WAKE always runs to completion, even if `want` drops. The settle period is never aborted.
- ON (`clk_en`=1, `ack`=1):
  - `want`=0 → go to HOLD; cnt←0.
  - Otherwise stay in ON.
- HOLD (`clk_en`=1, `ack`=1):
  - `want`=1 → go to ON; cnt←0. Re-request is instant; no new WAKE.
  - Else cnt==IDLE_CYC-1 → go to OFF; `clk_en`←0 and `ack`←0 on the same edge.
  - Else cnt←cnt+1.
- Output relations:
  - `clk_en` is high in WAKE, ON and HOLD, and low only in OFF.
  - `ack` is high only in ON and HOLD.
  - `ack`=1 always implies `clk_en`=1.
- All outputs come straight from flops, with no combinational path from inputs to outputs.
- Counter rules:
  - The counter is never compared beyond the parameter bound.
  - It cannot wrap, because legal parameters are below 2^CNT_W.
  - It is cleared on every state entry.
- An illegal `state` encoding cannot occur; the default branch returns to OFF with `clk_en`=0 and `ack`=0.

## Timing
- Wake-up:
  - `want` sampled high at edge E0 in OFF → `clk_en`=1 after E0.
  - `ack`=1 after edge E0+WAKE_CYC.
- Shut-down:
  - `want` sampled low at edge F0 in ON → HOLD after F0.
  - `clk_en`=0 and `ack`=0 after edge F0+IDLE_CYC.
  - Total enable tail: IDLE_CYC+1 cycles after the last high sample.
- A `want` pulse of one cycle in OFF produces a complete cycle: WAKE for WAKE_CYC cycles, then ON for 1 cycle, then HOLD for IDLE_CYC cycles, then OFF.
- `want` re-asserting on the exact edge where HOLD would expire (cnt==IDLE_CYC-1): the request wins. Go to ON; `clk_en` stays 1 with no low glitch.
- Asynchronous `rst` assertion mid-operation:
  - `clk_en` and `ack` drop immediately, without waiting for an edge.
  - The gater may therefore see an enable fall at any phase; its latch absorbs this.
- Reset deassertion: the first evaluated edge is in OFF.

## Test plan
- Reset, then hold `req`=1 with WAKE_CYC=2 → `state` goes 0→1→2.
  - `clk_en` rises at edge 1; `ack` rises at edge 3.
  - Check `ack` never precedes `clk_en`.
- From ON, drop `req` with IDLE_CYC=8 → 8 edges in HOLD (`state`=3, `ack`=1).
  - `clk_en` and `ack` fall together at edge 9 after the drop; `state`=0.
- From HOLD, re-raise `req` at cnt=3, and separately at cnt=7 (expiry edge) → `state` returns to 2.
  - `clk_en` stays 1 throughout; `ack` stays 1.
- Pulse `req` for 1 cycle from OFF (WAKE_CYC=2, IDLE_CYC=8) → WAKE for 2 cycles, ON for 1, HOLD for 8, then OFF.
  - `clk_en` high for 11 cycles.
- Hold `force_on`=1 with `req`=0 → same wake sequence as `req`.
  - Drop `force_on` while `req`=1 → remains in ON.
- Assert `rst` asynchronously mid-WAKE and mid-HOLD → `clk_en`=0, `ack`=0, `state`=0 immediately.
  - After release with `req`=1, a fresh WAKE of WAKE_CYC cycles follows.
